// File: rtl/cfu_bank_stream_reader.sv
// Multi-bank scratchpad read CFU: single-word reads plus a strided,
// optionally bank-interleaved stream pointer, with a registered valid/ready response.
module cfu_bank_stream_reader #(
  parameter int NUM_BANKS   = 4,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [9:0]                  cmd_payload_function_id,
  input  logic [31:0]                 cmd_payload_inputs_0,
  input  logic [31:0]                 cmd_payload_inputs_1,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [31:0]                 rsp_payload_outputs_0,
  output logic [ADDR_W-1:0]           bank_addr,
  output logic [NUM_BANKS-1:0]        bank_ren,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_din
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int LAT_W  = 3;
  localparam logic [2:0] OP_READ      = 3'd0;
  localparam logic [2:0] OP_SETPTR    = 3'd1;
  localparam logic [2:0] OP_SETSTRIDE = 3'd2;
  localparam logic [2:0] OP_STREAM    = 3'd3;
  localparam logic [2:0] OP_STATUS    = 3'd4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  state_t               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0]    bank_addr_q, bank_addr_d;
  logic [NUM_BANKS-1:0] bank_ren_q, bank_ren_d;
  logic [BANK_W-1:0]    rd_bank_q, rd_bank_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic [BANK_W-1:0]    ptr_bank_q, ptr_bank_d;
  logic [ADDR_W-1:0]    ptr_addr_q, ptr_addr_d;
  logic [ADDR_W-1:0]    stride_q, stride_d;
  logic                 err_q, err_d;

  logic              accept_s, in0_ok_s, ptr_ok_s, is_read_s, lat_last_s;
  logic [2:0]        op_s;
  logic [DATA_W-1:0] sel_din_s;
  logic              unused_ok;

  assign op_s       = cmd_payload_function_id[2:0];
  assign accept_s   = cmd_valid && cmd_ready_q;
  assign in0_ok_s   = cmd_payload_inputs_0 < 32'(NUM_BANKS);
  assign ptr_ok_s   = 32'(ptr_bank_q) < 32'(NUM_BANKS);
  assign is_read_s  = ((op_s == OP_READ) && in0_ok_s) || ((op_s == OP_STREAM) && ptr_ok_s);
  assign lat_last_s = (lat_cnt_q == LAT_W'(MEM_LATENCY - 1));
  assign unused_ok  = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_1[31:ADDR_W]};

  // Select the data lane of the bank that was read.
  always_comb begin
    sel_din_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      sel_din_s = sel_din_s | ({DATA_W{rd_bank_q == BANK_W'(b)}} & bank_din[b*DATA_W +: DATA_W]);
    end
  end

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      bank_addr_q <= '0;
      bank_ren_q  <= '0;
      rd_bank_q   <= '0;
      lat_cnt_q   <= '0;
      ptr_bank_q  <= '0;
      ptr_addr_q  <= '0;
      stride_q    <= ADDR_W'(1);
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      bank_addr_q <= bank_addr_d;
      bank_ren_q  <= bank_ren_d;
      rd_bank_q   <= rd_bank_d;
      lat_cnt_q   <= lat_cnt_d;
      ptr_bank_q  <= ptr_bank_d;
      ptr_addr_q  <= ptr_addr_d;
      stride_q    <= stride_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = is_read_s ? S_ISSUE : S_RESP;
        else          state_d = S_IDLE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (lat_last_s) state_d = S_RESP;
        else            state_d = S_WAIT;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
        else           state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output-register and pointer updates; the read strobe is loaded at accept so it is high during ISSUE.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    rsp_data_d  = rsp_data_q;
    bank_addr_d = bank_addr_q;
    bank_ren_d  = '0;
    rd_bank_d   = rd_bank_q;
    lat_cnt_d   = lat_cnt_q;
    ptr_bank_d  = ptr_bank_q;
    ptr_addr_d  = ptr_addr_q;
    stride_d    = stride_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          lat_cnt_d = '0;
          case (op_s)
            OP_READ: begin
              if (in0_ok_s) begin
                rd_bank_d   = BANK_W'(cmd_payload_inputs_0);
                bank_addr_d = cmd_payload_inputs_1[ADDR_W-1:0];
                bank_ren_d  = {{(NUM_BANKS-1){1'b0}}, 1'b1} << BANK_W'(cmd_payload_inputs_0);
              end else begin
                rsp_data_d = 32'd0;
                err_d      = 1'b1;
              end
            end
            OP_SETPTR: begin
              rsp_data_d = 32'd0;
              if (in0_ok_s) begin
                ptr_bank_d = BANK_W'(cmd_payload_inputs_0);
                ptr_addr_d = cmd_payload_inputs_1[ADDR_W-1:0];
              end else begin
                err_d = 1'b1;
              end
            end
            OP_SETSTRIDE: begin
              rsp_data_d = 32'd0;
              stride_d   = cmd_payload_inputs_0[ADDR_W-1:0];
            end
            OP_STREAM: begin
              if (ptr_ok_s) begin
                rd_bank_d   = ptr_bank_q;
                bank_addr_d = ptr_addr_q;
                bank_ren_d  = {{(NUM_BANKS-1){1'b0}}, 1'b1} << ptr_bank_q;
                // Interleave walks the banks first and only steps the address on bank wrap.
                if (!cmd_payload_inputs_0[0]) begin
                  ptr_addr_d = ptr_addr_q + stride_q;
                end else if (ptr_bank_q == BANK_W'(NUM_BANKS - 1)) begin
                  ptr_bank_d = '0;
                  ptr_addr_d = ptr_addr_q + stride_q;
                end else begin
                  ptr_bank_d = ptr_bank_q + BANK_W'(1);
                end
              end else begin
                rsp_data_d = 32'd0;
                err_d      = 1'b1;
              end
            end
            OP_STATUS: rsp_data_d = {err_q, 7'd0, 8'(ptr_bank_q), 16'(ptr_addr_q)};
            default:   rsp_data_d = 32'd0;
          endcase
        end else begin
          lat_cnt_d = lat_cnt_q;
        end
      end
      S_ISSUE: lat_cnt_d = '0;
      S_WAIT: begin
        if (lat_last_s) rsp_data_d = sel_din_s;
        else            lat_cnt_d  = lat_cnt_q + LAT_W'(1);
      end
      S_RESP:  rsp_data_d = rsp_data_q;
      default: rsp_data_d = rsp_data_q;
    endcase
  end

  assign cmd_ready             = cmd_ready_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;
  assign bank_addr             = bank_addr_q;
  assign bank_ren              = bank_ren_q;

endmodule

// File: tb/tb_cfu_bank_stream_reader.sv
// Scoreboarded bench: a default-latency instance and a MEM_LATENCY=3 instance,
// each backed by a bank model returning word[a] = bank<<24 | a.
module tb_cfu_bank_stream_reader;
  localparam logic [2:0] OP_READ = 3'd0, OP_SETPTR = 3'd1, OP_SETSTRIDE = 3'd2;
  localparam logic [2:0] OP_STREAM = 3'd3, OP_STATUS = 3'd4, OP_NOP5 = 3'd5;

  logic clk, reset, rsp_ready, cmd_valid1, cmd_valid3, sel3;
  logic [9:0]   fid;
  logic [31:0]  in0, in1;
  logic         cmd_ready1, cmd_ready3, rsp_valid1, rsp_valid3;
  logic [31:0]  out1, out3;
  logic [13:0]  addr1, addr3;
  logic [3:0]   ren1, ren3;
  logic [127:0] din1, din3;
  logic [3:0]   p1_ren;
  logic [13:0]  p1_addr;
  logic [3:0]   p3_ren [3];
  logic [13:0]  p3_addr [3];
  logic         cur_ready, cur_valid;
  logic [3:0]   cur_ren;
  logic [13:0]  cur_addr;
  logic [31:0]  q1 [$];
  logic [31:0]  q3 [$];
  int total = 0, bad = 0;

  cfu_bank_stream_reader #(.NUM_BANKS(4), .ADDR_W(14), .DATA_W(32), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(out1),
    .bank_addr(addr1), .bank_ren(ren1), .bank_din(din1));

  cfu_bank_stream_reader #(.NUM_BANKS(4), .ADDR_W(14), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(out3),
    .bank_addr(addr3), .bank_ren(ren3), .bank_din(din3));

  assign cur_ready = sel3 ? cmd_ready3 : cmd_ready1;
  assign cur_valid = sel3 ? rsp_valid3 : rsp_valid1;
  assign cur_ren   = sel3 ? ren3 : ren1;
  assign cur_addr  = sel3 ? addr3 : addr1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input int b, input logic [13:0] a);
    return (32'(b) << 24) | 32'(a);
  endfunction

  // Bank models: data appears 1 (resp. 3) cycles after the cycle bank_ren is high.
  always @(posedge clk) begin
    p1_ren     <= ren1;
    p1_addr    <= addr1;
    p3_ren[0]  <= ren3;
    p3_addr[0] <= addr3;
    for (int k = 1; k < 3; k++) begin
      p3_ren[k]  <= p3_ren[k-1];
      p3_addr[k] <= p3_addr[k-1];
    end
  end

  always_comb begin
    din1 = '0;
    din3 = '0;
    for (int b = 0; b < 4; b++) begin
      din1[b*32 +: 32] = (p1_ren[b] === 1'b1)    ? word(b, p1_addr)    : 32'hBAD0_0000;
      din3[b*32 +: 32] = (p3_ren[2][b] === 1'b1) ? word(b, p3_addr[2]) : 32'hBAD0_0000;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitors: pop the expected word on every response handshake.
  always @(negedge clk) begin
    if (rsp_valid1 === 1'b1 && rsp_ready === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp1_unexpected: got %h want no response", out1);
      end else begin
        chk("rsp1_data", out1, q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid3 === 1'b1 && rsp_ready === 1'b1) begin
      if (q3.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp3_unexpected: got %h want no response", out3);
      end else begin
        chk("rsp3_data", out3, q3.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (cur_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 32'(cur_ready), 32'd1);
  endtask

  // Issue one command; lat is the cycle (1 = cycle after the accept edge) in which rsp_valid rises.
  task automatic issue(input bit d3, input logic [2:0] op, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] exp, input int lat, input logic [3:0] ren, input logic [13:0] addr);
    int n;
    sel3 = d3;
    wait_ready();
    if (d3) q3.push_back(exp);
    else    q1.push_back(exp);
    fid = {7'h55, op};
    in0 = a0;
    in1 = a1;
    if (d3) cmd_valid3 = 1'b1;
    else    cmd_valid1 = 1'b1;
    @(posedge clk); #1;
    cmd_valid1 = 1'b0;
    cmd_valid3 = 1'b0;
    in0 = 32'hFFFF_FFFF;
    in1 = $urandom;
    n = 1;
    chk("ren_pulse", 32'(cur_ren), 32'(ren));
    if (ren != 4'd0) chk("bank_addr", 32'(cur_addr), 32'(addr));
    while (cur_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) chk("ren_single", 32'(cur_ren), 32'd0);
    end
    chk("latency", n, lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cmd_valid1 = 1'b0; cmd_valid3 = 1'b0; sel3 = 1'b0;
    fid = 10'd0; in0 = 32'd0; in1 = 32'd0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready1), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    chk("rst_payload", out1, 32'd0);
    chk("rst_ren", 32'(ren1), 32'd0);
    chk("rst_addr", 32'(addr1), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(cmd_ready1), 32'd1);

    issue(0, OP_READ, 32'd2, 32'h10, 32'h0200_0010, 3, 4'b0100, 14'h10);
    issue(0, OP_SETPTR, 32'd1, 32'h3FFE, 32'd0, 1, 4'd0, 14'd0);
    issue(0, OP_SETSTRIDE, 32'd1, 32'd0, 32'd0, 1, 4'd0, 14'd0);
    issue(0, OP_STREAM, 32'd0, 32'd0, 32'h0100_3FFE, 3, 4'b0010, 14'h3FFE);
    issue(0, OP_STREAM, 32'd0, 32'd0, 32'h0100_3FFF, 3, 4'b0010, 14'h3FFF);
    issue(0, OP_STREAM, 32'd0, 32'd0, 32'h0100_0000, 3, 4'b0010, 14'h0000);
    issue(0, OP_STATUS, 32'd0, 32'd0, 32'h0001_0001, 1, 4'd0, 14'd0);
    issue(0, OP_SETPTR, 32'd2, 32'd5, 32'd0, 1, 4'd0, 14'd0);
    issue(0, OP_SETSTRIDE, 32'h3FFE, 32'd0, 32'd0, 1, 4'd0, 14'd0);
    issue(0, OP_STREAM, 32'd1, 32'd0, 32'h0200_0005, 3, 4'b0100, 14'd5);
    issue(0, OP_STREAM, 32'd1, 32'd0, 32'h0300_0005, 3, 4'b1000, 14'd5);
    issue(0, OP_STREAM, 32'd1, 32'd0, 32'h0000_0003, 3, 4'b0001, 14'd3);
    issue(0, OP_STREAM, 32'd1, 32'd0, 32'h0100_0003, 3, 4'b0010, 14'd3);
    // After four interleaved reads the pointer has moved on to (2,3).
    issue(0, OP_STATUS, 32'd0, 32'd0, 32'h0002_0003, 1, 4'd0, 14'd0);
    issue(0, OP_READ, 32'd3, 32'hFFFF_0020, 32'h0300_0020, 3, 4'b1000, 14'h20);

    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(0, OP_READ, 32'd0, 32'd7, 32'h0000_0007, 3, 4'b0001, 14'd7);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid1), 32'd1);
      chk("bp_payload", out1, 32'h0000_0007);
      chk("bp_cmd_ready", 32'(cmd_ready1), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 32'(cmd_ready1), 32'd1);
    chk("bp_release_valid", 32'(rsp_valid1), 32'd0);

    issue(0, OP_STATUS, 32'd0, 32'd0, 32'h0002_0003, 1, 4'd0, 14'd0);
    issue(0, OP_READ, 32'd4, 32'd0, 32'd0, 1, 4'd0, 14'd0);
    issue(0, OP_STATUS, 32'd0, 32'd0, 32'h8002_0003, 1, 4'd0, 14'd0);
    issue(0, OP_SETPTR, 32'd9, 32'h100, 32'd0, 1, 4'd0, 14'd0);
    issue(0, OP_STATUS, 32'd0, 32'd0, 32'h8002_0003, 1, 4'd0, 14'd0);
    issue(0, OP_READ, 32'd1, 32'd2, 32'h0100_0002, 3, 4'b0010, 14'd2);
    issue(0, OP_STATUS, 32'd0, 32'd0, 32'h8002_0003, 1, 4'd0, 14'd0);
    issue(0, OP_NOP5, 32'h1234, 32'h5678, 32'd0, 1, 4'd0, 14'd0);

    issue(1, OP_READ, 32'd3, 32'h44, 32'h0300_0044, 5, 4'b1000, 14'h44);
    @(posedge clk); #1;
    sel3 = 1'b1;
    wait_ready();
    fid = {7'd0, OP_READ}; in0 = 32'd1; in1 = 32'h20; cmd_valid3 = 1'b1;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    chk("l3_ren", 32'(ren3), 32'h2);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid3), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready3), 32'd0);
    chk("mid_rst_ren", 32'(ren3), 32'd0);
    chk("mid_rst_addr", 32'(addr3), 32'd0);
    chk("mid_rst_payload", out3, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_rst_hold", 32'(rsp_valid3), 32'd0);
    end
    @(negedge clk); reset = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("no_stale_rsp", 32'(rsp_valid3), 32'd0);
    end
    issue(0, OP_STATUS, 32'd0, 32'd0, 32'h0000_0000, 1, 4'd0, 14'd0);
    issue(1, OP_STATUS, 32'd0, 32'd0, 32'h0000_0000, 1, 4'd0, 14'd0);
    issue(1, OP_STREAM, 32'd0, 32'd0, 32'h0000_0000, 5, 4'b0001, 14'd0);
    issue(1, OP_STREAM, 32'd0, 32'd0, 32'h0000_0001, 5, 4'b0001, 14'd1);
    issue(1, OP_STATUS, 32'd0, 32'd0, 32'h0000_0002, 1, 4'd0, 14'd0);
    issue(1, OP_READ, 32'd2, 32'h1234, 32'h0200_1234, 5, 4'b0100, 14'h1234);

    repeat (3) @(posedge clk);
    #1;
    chk("q1_drained", q1.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
